// File: rtl/spike_collector_if.sv
// Valid/ready packet channel shared by the collector's input and output sides.
//   valid : packet on data is valid (driven by master)
//   ready : slave accepts the packet when valid && ready at a rising edge
//   data  : WIDTH-bit packet (driven by master)
interface spike_collector_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/spike_collector.sv
// Sink for the adder stage's packet stream. It stores the latest membrane
// potential per adder and builds a per-timestep spike map. When a timestep
// is complete, it sends one spike-row packet and then replays each adder's
// potential back to that adder.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_ch      : incoming packets (slave side of a valid/ready channel)
//   out_ch     : spike-row and replay packets (master side)
//   timestep   : index of the timestep currently being collected
//   spike_map  : bit t*NUM_ADDERS+a set when adder a spiked in timestep t
//   err        : sticky protocol-error flag
//   all_done   : high once the final timestep's report has been sent
//
// state   | meaning
// COLLECT | accept packets until done and every potential have arrived
// REPORT  | send the spike row of the current timestep
// REPLAY  | send the stored potential back to adder rep_idx
// DONE    | final report sent; idle until reset
module spike_collector #(
  parameter int         WIDTH           = 64,
  parameter int         NUM_ADDERS      = 5,
  parameter int         TIMESTEPS       = 5,
  parameter logic [3:0] ADDER_BASE_ADDR = 4'b0110,
  parameter logic [3:0] MEM_ADDR        = 4'b0000,
  parameter logic [3:0] OUT_ADDR        = 4'b1111
) (
  input  logic                             clk,
  input  logic                             rst,
  spike_collector_if.slave                 in_ch,
  spike_collector_if.master                out_ch,
  output logic [2:0]                       timestep,
  output logic [TIMESTEPS*NUM_ADDERS-1:0]  spike_map,
  output logic                             err,
  output logic                             all_done
);

  typedef enum logic [1:0] {COLLECT, REPORT, REPLAY, DONE} state_t;

  state_t     state;
  // Sized for the largest legal adder count so a 3-bit index never overruns.
  logic [7:0] pot [8];
  logic [7:0] pot_seen;
  logic       done_seen;
  logic [2:0] rep_idx;

  logic [3:0]       src;
  logic [3:0]       pot_off;
  logic [1:0]       typ;
  logic [7:0]       payload;
  logic             accept;
  logic             is_pot;
  logic             pot_ok;
  logic             is_done;
  logic             is_spike;
  logic             spike_ok;
  logic             pkt_err;
  logic             complete;
  logic [2:0]       pot_idx;
  logic [2:0]       sp_t;
  logic [2:0]       sp_a;
  logic [7:0]       pot_seen_nxt;
  logic             done_seen_nxt;
  logic [5:0]       spike_bit;
  logic [7:0]       row;
  logic [2:0]       rep_next;
  logic [WIDTH-1:0] report_pkt;
  logic [WIDTH-1:0] replay_pkt;
  logic             unused_ok;

  always_comb begin
    src      = in_ch.data[63:60];
    typ      = in_ch.data[55:54];
    payload  = in_ch.data[7:0];
    accept   = in_ch.valid && in_ch.ready;

    // Sources below the base wrap to a large offset and so fail the range check.
    pot_off  = src - ADDER_BASE_ADDR;
    pot_idx  = pot_off[2:0];
    is_pot   = (typ == 2'b10);
    pot_ok   = is_pot && (pot_off < 4'(NUM_ADDERS));

    // Adder index 7 is never legal, so a[2:0]==7 marks the done packet.
    is_done  = (typ == 2'b11) && (payload[2:0] == 3'b111);
    is_spike = (typ == 2'b11) && !is_done;
    sp_t     = payload[5:3];
    sp_a     = payload[2:0];
    spike_ok = is_spike && (sp_t == timestep) && (sp_a < 3'(NUM_ADDERS));
    spike_bit = 6'(sp_t) * 6'(NUM_ADDERS) + 6'(sp_a);

    pkt_err  = !typ[1] || (is_pot && !pot_ok) || (pot_ok && pot_seen[pot_idx])
               || (is_spike && !spike_ok);

    pot_seen_nxt  = pot_seen | (pot_ok ? (8'd1 << pot_idx) : 8'd0);
    done_seen_nxt = done_seen | is_done;
    complete      = accept && done_seen_nxt && (&pot_seen_nxt[NUM_ADDERS-1:0]);

    row = '0;
    row[NUM_ADDERS-1:0] = spike_map[timestep*NUM_ADDERS +: NUM_ADDERS];

    report_pkt          = '0;
    report_pkt[63:60]   = MEM_ADDR;
    report_pkt[59:56]   = OUT_ADDR;
    report_pkt[55:54]   = 2'b11;
    report_pkt[10:8]    = timestep;
    report_pkt[7:0]     = row;

    // Packet to load into out_data at the coming handshake.
    rep_next            = (state == REPORT) ? 3'd0 : rep_idx + 3'd1;
    replay_pkt          = '0;
    replay_pkt[63:60]   = MEM_ADDR;
    replay_pkt[59:56]   = ADDER_BASE_ADDR + 4'(rep_next);
    replay_pkt[55:54]   = 2'b10;
    replay_pkt[37:30]   = pot[rep_next];

    unused_ok = ^{in_ch.data[59:56], in_ch.data[53:8], payload[7:6]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= COLLECT;
      in_ch.ready    <= 1'b0;
      out_ch.valid   <= 1'b0;
      out_ch.data    <= '0;
      timestep       <= '0;
      spike_map      <= '0;
      err            <= 1'b0;
      all_done       <= 1'b0;
      pot_seen       <= '0;
      done_seen      <= 1'b0;
      rep_idx        <= '0;
      for (int k = 0; k < 8; k++) pot[k] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          in_ch.ready <= 1'b1;
          if (accept) begin
            if (pkt_err)  err <= 1'b1;
            if (pot_ok)   pot[pot_idx] <= payload;
            if (spike_ok) spike_map[spike_bit] <= 1'b1;
            pot_seen  <= pot_seen_nxt;
            done_seen <= done_seen_nxt;
            if (complete) begin
              state        <= REPORT;
              in_ch.ready  <= 1'b0;
              out_ch.valid <= 1'b1;
              out_ch.data  <= report_pkt;
            end
          end
        end
        REPORT: begin
          if (out_ch.ready) begin
            if (timestep == 3'(TIMESTEPS-1)) begin
              state        <= DONE;
              out_ch.valid <= 1'b0;
              out_ch.data  <= '0;
              all_done     <= 1'b1;
            end else begin
              state       <= REPLAY;
              rep_idx     <= 3'd0;
              out_ch.data <= replay_pkt;
            end
          end
        end
        REPLAY: begin
          if (out_ch.ready) begin
            if (rep_idx == 3'(NUM_ADDERS-1)) begin
              state        <= COLLECT;
              out_ch.valid <= 1'b0;
              out_ch.data  <= '0;
              in_ch.ready  <= 1'b1;
              timestep     <= timestep + 3'd1;
              pot_seen     <= '0;
              done_seen    <= 1'b0;
            end else begin
              rep_idx     <= rep_next;
              out_ch.data <= replay_pkt;
            end
          end
        end
        DONE: begin
          in_ch.ready  <= 1'b0;
          out_ch.valid <= 1'b0;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_collector.sv
module tb_spike_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  timestep;
  logic [24:0] spike_map;
  logic        err;
  logic        all_done;

  spike_collector_if #(.WIDTH(64)) in_ch ();
  spike_collector_if #(.WIDTH(64)) out_ch ();

  spike_collector dut (
    .clk(clk), .rst(rst), .in_ch(in_ch), .out_ch(out_ch),
    .timestep(timestep), .spike_map(spike_map), .err(err), .all_done(all_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_pot [5];
  bit   [4:0]  m_seen;
  bit          m_done;
  logic [24:0] m_map;
  bit          m_err;
  int          m_ts;
  logic [63:0] pq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_pot(input logic [3:0] src, input logic [7:0] v);
    return {src, 4'h0, 2'b10, 46'b0, v};
  endfunction

  function automatic logic [63:0] mk_ctl(input logic [7:0] pl);
    return {4'h1, 4'h0, 2'b11, 46'b0, pl};
  endfunction

  function automatic logic [63:0] rep_pkt();
    logic [24:0] sh;
    sh = m_map >> (m_ts * 5);
    return {4'h0, 4'hF, 2'b11, 43'b0, 3'(m_ts), 3'b0, sh[4:0]};
  endfunction

  function automatic logic [63:0] rpl_pkt(input int i);
    return {4'h0, 4'(6 + i), 2'b10, 16'b0, m_pot[i], 30'b0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_pot[i] = 8'h0;
    m_seen = '0; m_done = 0; m_map = '0; m_err = 0; m_ts = 0;
  endtask

  task automatic model_apply(input logic [63:0] d, output bit cmpl);
    int a, t;
    logic [7:0] pl;
    pl = d[7:0];
    case (d[55:54])
      2'b10: begin
        a = int'(d[63:60]) - 6;
        if (a >= 0 && a < 5) begin
          if (m_seen[a]) m_err = 1;
          m_pot[a] = pl;
          m_seen[a] = 1;
        end else m_err = 1;
      end
      2'b11: begin
        t = int'(pl[5:3]);
        a = int'(pl[2:0]);
        if (a == 7) m_done = 1;
        else if (t == m_ts && a < 5) m_map[t*5 + a] = 1'b1;
        else m_err = 1;
      end
      default: m_err = 1;
    endcase
    cmpl = m_done && (m_seen == 5'b11111);
  endtask

  task automatic send(input logic [63:0] d);
    int n = 0;
    bit cmpl;
    @(negedge clk);
    in_ch.valid = 1'b1;
    in_ch.data  = d;
    while (!in_ch.ready && n < 50) begin @(negedge clk); n++; end
    chk("accept wait", (n < 50), 1);
    @(posedge clk); #1;
    in_ch.valid = 1'b0;
    if (n < 50) begin
      model_apply(d, cmpl);
      chk("out_valid after pkt", out_ch.valid, cmpl);
      chk("in_ready after pkt", in_ch.ready, !cmpl);
      chk("spike_map", spike_map, m_map);
      chk("err", err, m_err);
      chk("timestep", timestep, m_ts);
    end
  endtask

  task automatic recv(input logic [63:0] exp, input int stall, input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_ch.valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, " gap"}, n, 0);
    chk(tag, out_ch.data, exp);
    chk({tag, " in_ready"}, in_ch.ready, 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, " hold data"}, out_ch.data, exp);
      chk({tag, " hold valid"}, out_ch.valid, 1);
      chk({tag, " hold in_ready"}, in_ch.ready, 0);
    end
    out_ch.ready = 1'b1;
    @(posedge clk); #1;
    out_ch.ready = 1'b0;
  endtask

  task automatic tail_replay(input int from_i);
    for (int i = from_i; i < 5; i++) recv(rpl_pkt(i), $urandom_range(0, 2), "replay");
    m_ts++; m_seen = '0; m_done = 0;
    chk("timestep next", timestep, m_ts);
    chk("in_ready next", in_ch.ready, 1);
    chk("out_valid idle", out_ch.valid, 0);
  endtask

  task automatic play_ts();
    foreach (pq[k]) send(pq[k]);
    recv(rep_pkt(), $urandom_range(0, 2), "report");
    if (m_ts == 4) begin
      in_ch.valid = 1'b1;
      in_ch.data  = mk_pot(4'h6, 8'h55);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("done out_valid", out_ch.valid, 0);
        chk("done all_done", all_done, 1);
        chk("done in_ready", in_ch.ready, 0);
      end
      in_ch.valid = 1'b0;
    end else tail_replay(0);
  endtask

  task automatic gen_ts();
    int h, j, a;
    logic [63:0] held, tmp;
    pq.delete();
    h = $urandom_range(0, 5);
    for (int i = 0; i < 5; i++) if (i != h) pq.push_back(mk_pot(4'(6 + i), 8'($urandom_range(0, 255))));
    if (h != 5) pq.push_back(mk_ctl({5'($urandom_range(0, 31)), 3'b111}));
    held = (h == 5) ? mk_ctl({5'($urandom_range(0, 31)), 3'b111})
                    : mk_pot(4'(6 + h), 8'($urandom_range(0, 255)));
    for (int e = 0; e < int'($urandom_range(1, 4)); e++) begin
      case ($urandom_range(0, 6))
        0, 1: pq.push_back(mk_ctl({2'b0, 3'(m_ts), 3'($urandom_range(0, 4))}));
        2: pq.push_back(mk_ctl({2'b0, 3'(m_ts), 3'($urandom_range(5, 6))}));
        3: pq.push_back(mk_ctl({2'b0, 3'((m_ts + $urandom_range(1, 7)) % 8), 3'($urandom_range(0, 4))}));
        4: pq.push_back(mk_pot(($urandom_range(0, 1) != 0) ? 4'($urandom_range(11, 15))
                                                            : 4'($urandom_range(0, 5)), 8'hA5));
        5: pq.push_back({4'h6, 4'h0, 1'b0, 1'($urandom_range(0, 1)), 46'b0, 8'($urandom_range(0, 255))});
        default: begin
          a = $urandom_range(0, 4);
          if (a != h) pq.push_back(mk_pot(4'(6 + a), 8'($urandom_range(0, 255))));
        end
      endcase
    end
    for (int i = pq.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = pq[i]; pq[i] = pq[j]; pq[j] = tmp;
    end
    pq.push_back(held);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_ch.valid = 1'b1;
    in_ch.data  = mk_pot(4'h6, 8'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ch.ready, 0);
    chk("rst out_valid", out_ch.valid, 0);
    chk("rst out_data", out_ch.data, 0);
    chk("rst timestep", timestep, 0);
    chk("rst spike_map", spike_map, 0);
    chk("rst err", err, 0);
    chk("rst all_done", all_done, 0);
    @(negedge clk);
    rst = 1'b0;
    in_ch.valid = 1'b0;
    @(posedge clk); #1;
    chk("post-rst in_ready", in_ch.ready, 1);
    model_reset();
  endtask

  initial begin
    in_ch.valid  = 1'b0;
    in_ch.data   = '0;
    out_ch.ready = 1'b0;
    model_reset();
    do_reset();

    // timestep 0, done arriving ahead of the last two potentials
    pq.delete();
    pq.push_back(mk_pot(4'h6, 8'h03));
    pq.push_back(mk_pot(4'h7, 8'h05));
    pq.push_back(mk_pot(4'h8, 8'h10));
    pq.push_back(mk_ctl(8'h02));
    pq.push_back(mk_ctl(8'h0F));
    pq.push_back(mk_pot(4'h9, 8'h01));
    pq.push_back(mk_pot(4'hA, 8'h02));
    foreach (pq[k]) send(pq[k]);
    recv(64'h0FC0_0000_0000_0004, 0, "report0");
    recv(64'h0680_0000_C000_0000, 0, "replay0");
    recv(64'h0780_0001_4000_0000, 3, "replay1");
    tail_replay(2);
    chk("spike bit2", spike_map[2], 1);

    // error packets during timestep 1
    send(mk_ctl(8'h0E));
    send(mk_ctl(8'h10));
    send(mk_pot(4'hC, 8'h33));
    chk("err sticky", err, 1);

    while (m_ts < 5 && checks < 5000) begin
      gen_ts();
      play_ts();
      if (all_done) break;
    end
    chk("all_done end", all_done, 1);

    // second run: reset while a replay packet is pending
    do_reset();
    gen_ts();
    foreach (pq[k]) send(pq[k]);
    recv(rep_pkt(), 0, "report r2");
    recv(rpl_pkt(0), 1, "replay r2");
    recv(rpl_pkt(1), 0, "replay r2");
    @(negedge clk);
    chk("pending replay", out_ch.valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid rst out_valid", out_ch.valid, 0);
    chk("mid rst out_data", out_ch.data, 0);
    chk("mid rst in_ready", in_ch.ready, 0);
    chk("mid rst timestep", timestep, 0);
    chk("mid rst spike_map", spike_map, 0);
    chk("mid rst err", err, 0);
    chk("mid rst all_done", all_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid rst in_ready after", in_ch.ready, 1);
    chk("mid rst out_valid after", out_ch.valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
